// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 1-3 byte instructions from byte memory and hands them to execute over valid/ready.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_hold,
  output logic                  pc_jump_en,
  output logic [ADDR_WIDTH-1:0] pc_jump_addr,
  output logic [1:0]            instr_size,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand1,
  output logic [DATA_WIDTH-1:0] operand2,
  input  logic                  jump_req,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  halt_req,
  output logic                  halted
);
  typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_B1, FETCH_B2, VALID, HALT} state_t;
  state_t state, state_nx;
  logic [1:0] size_dec;
  logic [ADDR_WIDTH-1:0] offs;
  logic hs;
  assign size_dec = mem_rdata[DATA_WIDTH-1] ? 2'd3 : mem_rdata[DATA_WIDTH-2] ? 2'd2 : 2'd1;
  assign hs = (state == VALID) && instr_ready;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = FETCH_OP;
      FETCH_OP: state_nx = mem_ack ? ((size_dec == 2'd1) ? VALID : FETCH_B1) : FETCH_OP;
      FETCH_B1: state_nx = mem_ack ? ((instr_size == 2'd2) ? VALID : FETCH_B2) : FETCH_B1;
      FETCH_B2: state_nx = mem_ack ? VALID : FETCH_B2;
      VALID:    state_nx = instr_ready ? (halt_req ? HALT : FETCH_OP) : VALID;
      HALT:     state_nx = halt_req ? HALT : FETCH_OP;
      default:  state_nx = IDLE;
    endcase
  end
  // operand bytes follow the opcode, wrapping modulo the address space
  always_comb begin
    offs = (state == FETCH_B1) ? ADDR_WIDTH'(1) : (state == FETCH_B2) ? ADDR_WIDTH'(2) : '0;
    mem_addr = pc + offs;
    mem_req = (state == FETCH_OP) || (state == FETCH_B1) || (state == FETCH_B2);
    instr_valid = state == VALID;
    halted = state == HALT;
    pc_hold = !hs;
    pc_jump_en = hs && jump_req;
    pc_jump_addr = (hs && jump_req) ? jump_addr : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opcode <= '0;
      operand1 <= '0;
      operand2 <= '0;
      instr_size <= 2'd1;
    end else begin
      state <= state_nx;
      if (state == FETCH_OP && mem_ack) begin
        opcode <= mem_rdata;
        operand1 <= '0;
        operand2 <= '0;
        instr_size <= size_dec;
      end
      if (state == FETCH_B1 && mem_ack) operand1 <= mem_rdata;
      if (state == FETCH_B2 && mem_ack) operand2 <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios against a PC model and a variable-latency byte memory.
module tb_fetch_sequencer;
  logic clk = 0;
  logic rst_n = 0;
  logic [8:0] pc, pc_init = 0;
  logic pc_hold, pc_jump_en, mem_req, mem_ack, instr_valid, halted;
  logic [8:0] pc_jump_addr, mem_addr, jump_addr = 0;
  logic [1:0] instr_size;
  logic [7:0] mem_rdata, opcode, operand1, operand2;
  logic instr_ready = 0, jump_req = 0, halt_req = 0;
  logic [7:0] mem [512];
  int ack_delay = 0, wait_cnt = 0, hs_cnt = 0;
  int checks = 0, errors = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_hold(pc_hold), .pc_jump_en(pc_jump_en),
    .pc_jump_addr(pc_jump_addr), .instr_size(instr_size), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
    .operand1(operand1), .operand2(operand2), .jump_req(jump_req),
    .jump_addr(jump_addr), .halt_req(halt_req), .halted(halted)
  );

  always #5 clk = ~clk;

  assign mem_ack = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= 0;
    else wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= pc_init;
    else if (!pc_hold) pc <= pc_jump_en ? pc_jump_addr : pc + 9'(instr_size);

  always @(posedge clk)
    if (instr_valid && instr_ready) hs_cnt <= hs_cnt + 1;

  task automatic do_reset(input logic [8:0] init, input int dly);
    instr_ready = 0; jump_req = 0; halt_req = 0; ack_delay = dly;
    pc_init = init; rst_n = 1;
    #1 rst_n = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({mem_req, instr_valid, pc_hold, pc_jump_en, halted} !== 5'b00100) begin
      errors++; $display("FAIL reset_ctl got %b exp 00100", {mem_req, instr_valid, pc_hold, pc_jump_en, halted});
    end
    checks++;
    if ({pc_jump_addr, instr_size, opcode, operand1, operand2} !== {9'h0, 2'd1, 24'h0}) begin
      errors++; $display("FAIL reset_data got %h %h %h %h %h", pc_jump_addr, instr_size, opcode, operand1, operand2);
    end
  endtask

  task automatic test_single_byte;
    mem[0] = 8'h05;
    do_reset(9'h000, 0);
    instr_ready = 1;
    @(negedge clk);
    checks++;
    if (!(mem_req === 1 && mem_addr === 9'h000)) begin
      errors++; $display("FAIL single_req got req=%b addr=%h exp req=1 addr=000", mem_req, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({instr_valid, opcode, instr_size, pc_hold} !== {1'b1, 8'h05, 2'd1, 1'b0}) begin
      errors++; $display("FAIL single_valid got v=%b op=%h sz=%0d hold=%b exp 1 05 1 0", instr_valid, opcode, instr_size, pc_hold);
    end
    @(negedge clk);
    instr_ready = 0;
    checks++;
    if ({pc_hold, mem_req, mem_addr, pc} !== {1'b1, 1'b1, 9'h001, 9'h001}) begin
      errors++; $display("FAIL single_next got hold=%b req=%b addr=%h pc=%h exp 1 1 001 001", pc_hold, mem_req, mem_addr, pc);
    end
  endtask

  task automatic test_three_byte_slow;
    logic [8:0] addrs [3];
    int n = 0;
    mem[9'h10] = 8'h83; mem[9'h11] = 8'hAA; mem[9'h12] = 8'hBB;
    do_reset(9'h010, 3);
    instr_ready = 1;
    for (int i = 0; i < 60 && !instr_valid; i++) begin
      if (mem_ack) begin
        if (n < 3) addrs[n] = mem_addr;
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 3 || addrs[0] !== 9'h010 || addrs[1] !== 9'h011 || addrs[2] !== 9'h012) begin
      errors++; $display("FAIL slow_addrs got n=%0d %h %h %h exp 3 010 011 012", n, addrs[0], addrs[1], addrs[2]);
    end
    checks++;
    if ({instr_valid, opcode, operand1, operand2, instr_size} !== {1'b1, 8'h83, 8'hAA, 8'hBB, 2'd3}) begin
      errors++; $display("FAIL slow_instr got v=%b %h %h %h sz=%0d exp 1 83 AA BB 3", instr_valid, opcode, operand1, operand2, instr_size);
    end
    @(negedge clk);
    instr_ready = 0;
    checks++;
    if (pc !== 9'h013) begin
      errors++; $display("FAIL slow_pc got %h exp 013", pc);
    end
  endtask

  task automatic test_wrap;
    logic [8:0] addrs [3];
    int n = 0;
    mem[511] = 8'h41; mem[0] = 8'h77; mem[1] = 8'h99;
    do_reset(9'h1FF, 0);
    instr_ready = 1;
    for (int i = 0; i < 20 && !instr_valid; i++) begin
      if (mem_ack) begin
        if (n < 3) addrs[n] = mem_addr;
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 2 || addrs[0] !== 9'h1FF || addrs[1] !== 9'h000) begin
      errors++; $display("FAIL wrap_addrs got n=%0d %h %h exp 2 1ff 000", n, addrs[0], addrs[1]);
    end
    checks++;
    if ({instr_valid, opcode, operand1, operand2, instr_size} !== {1'b1, 8'h41, 8'h77, 8'h00, 2'd2}) begin
      errors++; $display("FAIL wrap_instr got v=%b %h %h %h sz=%0d exp 1 41 77 00 2", instr_valid, opcode, operand1, operand2, instr_size);
    end
    @(negedge clk);
    instr_ready = 0;
    checks++;
    if (pc !== 9'h001) begin
      errors++; $display("FAIL wrap_pc got %h exp 001", pc);
    end
  endtask

  task automatic test_stall;
    int hs0;
    mem[9'h20] = 8'h42; mem[9'h21] = 8'h5A; mem[9'h22] = 8'h00;
    do_reset(9'h020, 0);
    for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({instr_valid, opcode, operand1, pc_hold, mem_req, pc} !== {1'b1, 8'h42, 8'h5A, 1'b1, 1'b0, 9'h020}) begin
        errors++; $display("FAIL stall_hold cyc=%0d got v=%b %h %h hold=%b req=%b pc=%h", i, instr_valid, opcode, operand1, pc_hold, mem_req, pc);
      end
      @(negedge clk);
    end
    instr_ready = 1;
    #1;
    checks++;
    if (pc_hold !== 1'b0) begin
      errors++; $display("FAIL stall_release got hold=%b exp 0", pc_hold);
    end
    @(negedge clk);
    instr_ready = 0;
    checks++;
    if ({pc, instr_valid} !== {9'h022, 1'b0}) begin
      errors++; $display("FAIL stall_after got pc=%h v=%b exp 022 0", pc, instr_valid);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (hs_cnt - hs0 !== 1) begin
      errors++; $display("FAIL stall_hs_count got %0d exp 1", hs_cnt - hs0);
    end
  endtask

  task automatic test_jump_halt;
    mem[9'h30] = 8'h01; mem[9'h1F0] = 8'h02;
    do_reset(9'h030, 0);
    for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    checks++;
    if (pc_jump_en !== 1'b0) begin
      errors++; $display("FAIL jump_idle got en=%b exp 0", pc_jump_en);
    end
    jump_req = 1; jump_addr = 9'h1F0; halt_req = 1; instr_ready = 1;
    #1;
    checks++;
    if ({pc_jump_en, pc_jump_addr, pc_hold} !== {1'b1, 9'h1F0, 1'b0}) begin
      errors++; $display("FAIL jump_hs got en=%b addr=%h hold=%b exp 1 1f0 0", pc_jump_en, pc_jump_addr, pc_hold);
    end
    @(negedge clk);
    instr_ready = 0; jump_req = 0;
    checks++;
    if ({pc_jump_en, halted, pc, mem_req, instr_valid} !== {1'b0, 1'b1, 9'h1F0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL jump_halted got en=%b halted=%b pc=%h req=%b v=%b exp 0 1 1f0 0 0", pc_jump_en, halted, pc, mem_req, instr_valid);
    end
    @(negedge clk);
    checks++;
    if ({halted, mem_req} !== 2'b10) begin
      errors++; $display("FAIL halt_stay got halted=%b req=%b exp 1 0", halted, mem_req);
    end
    halt_req = 0;
    @(negedge clk);
    checks++;
    if ({halted, mem_req, mem_addr} !== {1'b0, 1'b1, 9'h1F0}) begin
      errors++; $display("FAIL halt_resume got halted=%b req=%b addr=%h exp 0 1 1f0", halted, mem_req, mem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch;
    mem[9'h40] = 8'h80; mem[0] = 8'h05;
    do_reset(9'h040, 5);
    for (int i = 0; i < 30 && !(mem_req && mem_addr == 9'h041); i++) @(negedge clk);
    checks++;
    if (!(mem_req === 1'b1 && mem_addr === 9'h041 && opcode === 8'h80)) begin
      errors++; $display("FAIL mid_reach got req=%b addr=%h op=%h exp 1 041 80", mem_req, mem_addr, opcode);
    end
    #2;
    pc_init = 9'h000;
    rst_n = 0;
    #1;
    checks++;
    if ({mem_req, instr_valid, pc_hold, pc_jump_en, halted, instr_size, opcode, operand1, operand2} !== {5'b00100, 2'd1, 24'h0}) begin
      errors++; $display("FAIL mid_async got %b sz=%0d %h %h %h", {mem_req, instr_valid, pc_hold, pc_jump_en, halted}, instr_size, opcode, operand1, operand2);
    end
    @(negedge clk);
    ack_delay = 0;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, pc} !== {1'b1, 9'h000, 9'h000}) begin
      errors++; $display("FAIL mid_restart got req=%b addr=%h pc=%h exp 1 000 000", mem_req, mem_addr, pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    test_reset;
    test_single_byte;
    test_three_byte_slow;
    test_wrap;
    test_stall;
    test_jump_halt;
    test_reset_mid_fetch;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
